// File: rtl/regfile_pkg.sv
// Shared Y86-64 definitions: architectural register IDs, register count and word width.
package y86_defs;

  typedef logic [3:0] reg_id_t;

  localparam int WORD_W = 64;
  localparam int NREGS  = 15;

  localparam reg_id_t RRAX  = 4'h0;
  localparam reg_id_t RRCX  = 4'h1;
  localparam reg_id_t RRDX  = 4'h2;
  localparam reg_id_t RRBX  = 4'h3;
  localparam reg_id_t RRSP  = 4'h4;
  localparam reg_id_t RRBP  = 4'h5;
  localparam reg_id_t RRSI  = 4'h6;
  localparam reg_id_t RRDI  = 4'h7;
  localparam reg_id_t R8    = 4'h8;
  localparam reg_id_t R9    = 4'h9;
  localparam reg_id_t R10   = 4'hA;
  localparam reg_id_t R11   = 4'hB;
  localparam reg_id_t R12   = 4'hC;
  localparam reg_id_t R13   = 4'hD;
  localparam reg_id_t R14   = 4'hE;
  localparam reg_id_t RNONE = 4'hF;

  // True when an ID names a physical register rather than "no register".
  function automatic logic is_reg(input reg_id_t id);
    return id != RNONE;
  endfunction

endpackage

// File: rtl/acenreg.sv
// Clocked register with load enable and asynchronous active-high reset to resetval.
module acenreg #(
  parameter int               width    = 64,
  parameter logic [width-1:0] resetval = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] data_d;
  logic [width-1:0] data_q;

  // NOTE: every path assigns data_d, so no latch is inferred; holding is an explicit mux.
  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) data_q <= resetval;
    else       data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/regfile.sv
// Y86-64 register file: 15 registers, two combinational read ports, two write ports (M wins ties).
module regfile
  import y86_defs::*;
#(
  parameter int               width    = WORD_W,
  parameter logic [width-1:0] resetval = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0]             srcA,
  input  logic [3:0]             srcB,
  output logic [width-1:0]       valA,
  output logic [width-1:0]       valB,
  input  logic [3:0]             dstE,
  input  logic [width-1:0]       valE,
  input  logic [3:0]             dstM,
  input  logic [width-1:0]       valM,
  output logic [NREGS*width-1:0] regs_flat
);

  logic [width-1:0] regs    [NREGS];
  logic [width-1:0] wr_data [NREGS];
  logic [NREGS-1:0] wr_en;

  // M is applied after E so a shared destination takes the memory-path value.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      wr_en[i]   = 1'b0;
      wr_data[i] = valE;
      if (is_reg(dstE) && dstE == reg_id_t'(i)) wr_en[i] = 1'b1;
      if (is_reg(dstM) && dstM == reg_id_t'(i)) begin
        wr_en[i]   = 1'b1;
        wr_data[i] = valM;
      end
    end
  end

  // NOTE: each register carries its own async reset; this is a flop array, not a RAM macro.
  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    acenreg #(
      .width    (width),
      .resetval (resetval)
    ) u_reg (
      .clock (clock),
      .reset (reset),
      .en    (wr_en[g]),
      .d     (wr_data[g]),
      .q     (regs[g])
    );
    assign regs_flat[g*width +: width] = regs[g];
  end

  // RNONE matches no index and falls through to zero; no bypass from the write ports.
  always_comb begin
    valA = '0;
    valB = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (srcA == reg_id_t'(i)) valA = regs[i];
      if (srcB == reg_id_t'(i)) valB = regs[i];
    end
  end

endmodule
